// File: rtl/rom_download_buffer.sv
// ioctl byte stream -> 16-bit little-endian word writes through a small FIFO.
// Optional ROM_CHECKSUM_EN adds a 16-bit running byte checksum output.
module rom_download_buffer #(
    parameter logic [7:0] ROM_INDEX  = 8'd0,
    parameter int         DEPTH_LOG2 = 2,
    parameter int         ADDR_W     = 24
) (
    input  logic              clk_48,
    input  logic              reset,
    input  logic              ioctl_download,
    input  logic [7:0]        ioctl_index,
    input  logic              ioctl_wr,
    input  logic [24:0]       ioctl_addr,
    input  logic [7:0]        ioctl_dout,
    output logic              ioctl_wait,
    output logic              mem_req,
    input  logic              mem_ack,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_data,
    output logic [1:0]        mem_be,
    output logic              busy,
`ifdef ROM_CHECKSUM_EN
    output logic [15:0]       checksum,
`endif
    output logic              done
);

    localparam int DEPTH = 2 ** DEPTH_LOG2;
    localparam int CW    = DEPTH_LOG2 + 1;
    localparam int EW    = ADDR_W + 18;
    localparam logic [CW-1:0]         WAIT_TH = CW'(DEPTH - 2);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE = DEPTH_LOG2'(1);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FLUSH, S_DONE} state_t;

    state_t                r_state;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_start_pend;
    logic                  r_req;
    logic                  r_wait;
    logic [EW-1:0]         r_fifo [DEPTH];
    logic [DEPTH_LOG2-1:0] r_wp;
    logic [DEPTH_LOG2-1:0] r_rp;
    logic [CW-1:0]         r_count;
    logic [7:0]            r_lo;
    logic                  r_lov;
    logic [ADDR_W-1:0]     r_pa;

    logic                  w_start;
    logic                  w_accept;
    logic                  w_flush;
    logic                  w_pop;
    logic [ADDR_W-1:0]     w_waddr;
    logic [1:0]            w_npush;
    logic [EW-1:0]         w_e0;
    logic [EW-1:0]         w_e1;
    logic [EW-1:0]         w_pend;
    logic [EW-1:0]         w_head;
    logic [7:0]            w_lo_nxt;
    logic                  w_lov_nxt;
    logic [ADDR_W-1:0]     w_pa_nxt;
    logic [CW-1:0]         w_cnt_nxt;

    assign w_start   = ioctl_download && (ioctl_index == ROM_INDEX);
    assign w_accept  = ioctl_wr && w_start;
    assign w_flush   = (r_state == S_LOAD) && !ioctl_download;
    assign w_pop     = r_req && mem_ack;
    assign w_waddr   = ioctl_addr[ADDR_W:1];
    assign w_pend    = {r_pa, 8'h00, r_lo, 2'b01};
    assign w_cnt_nxt = r_count + CW'(w_npush) - CW'(w_pop);
    assign w_head    = r_fifo[r_rp];

    // A pending low byte that cannot pair is always pushed ahead of new data.
    always_comb begin
        w_npush   = 2'd0;
        w_e0      = '0;
        w_e1      = '0;
        w_lo_nxt  = r_lo;
        w_lov_nxt = r_lov;
        w_pa_nxt  = r_pa;
        if (w_accept && !ioctl_addr[0]) begin
            if (r_lov) begin
                w_npush = 2'd1;
                w_e0    = w_pend;
            end
            w_lo_nxt  = ioctl_dout;
            w_lov_nxt = 1'b1;
            w_pa_nxt  = w_waddr;
        end else if (w_accept) begin
            w_lov_nxt = 1'b0;
            if (r_lov && (r_pa == w_waddr)) begin
                w_npush = 2'd1;
                w_e0    = {w_waddr, ioctl_dout, r_lo, 2'b11};
            end else if (r_lov) begin
                w_npush = 2'd2;
                w_e0    = w_pend;
                w_e1    = {w_waddr, ioctl_dout, 8'h00, 2'b10};
            end else begin
                w_npush = 2'd1;
                w_e0    = {w_waddr, ioctl_dout, 8'h00, 2'b10};
            end
        end else if (w_flush && r_lov) begin
            w_npush   = 2'd1;
            w_e0      = w_pend;
            w_lov_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk_48) begin
        if (w_npush != 2'd0) r_fifo[r_wp] <= w_e0;
        if (w_npush == 2'd2) r_fifo[r_wp + PTR_ONE] <= w_e1;
    end

    always_ff @(posedge clk_48) begin
        if (reset) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
            r_lo    <= '0;
            r_lov   <= 1'b0;
            r_pa    <= '0;
            r_wait  <= 1'b0;
            r_req   <= 1'b0;
        end else begin
            r_wp    <= r_wp + DEPTH_LOG2'(w_npush);
            r_rp    <= r_rp + DEPTH_LOG2'(w_pop);
            r_count <= w_cnt_nxt;
            r_lo    <= w_lo_nxt;
            r_lov   <= w_lov_nxt;
            r_pa    <= w_pa_nxt;
            r_wait  <= (w_cnt_nxt >= WAIT_TH);
            if (w_pop)
                r_req <= 1'b0;
            else if (r_count != '0)
                r_req <= 1'b1;
        end
    end

    always_ff @(posedge clk_48) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_start_pend <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                S_IDLE: if (w_start) begin
                    r_state <= S_LOAD;
                    r_busy  <= 1'b1;
                end
                S_LOAD: if (!ioctl_download) r_state <= S_FLUSH;
                S_FLUSH: begin
                    if (w_start) r_start_pend <= 1'b1;
                    if (w_cnt_nxt == '0) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                S_DONE: if (r_start_pend || w_start) begin
                    r_state      <= S_LOAD;
                    r_busy       <= 1'b1;
                    r_start_pend <= 1'b0;
                end else begin
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef ROM_CHECKSUM_EN
    logic [15:0] r_sum;

    always_ff @(posedge clk_48) begin
        if (reset)
            r_sum <= '0;
        else if ((r_state == S_IDLE) && w_start)
            r_sum <= w_accept ? {8'h00, ioctl_dout} : 16'h0000;
        else if (w_accept)
            r_sum <= r_sum + {8'h00, ioctl_dout};
    end

    assign checksum = r_sum;
`endif

    generate
        if (ADDR_W < 24) begin : g_hi_addr
            logic w_unused_hi;
            assign w_unused_hi = ^ioctl_addr[24:ADDR_W+1];
        end
    endgenerate

    assign ioctl_wait = r_wait;
    assign mem_req    = r_req;
    assign {mem_addr, mem_data, mem_be} = r_req ? w_head : '0;
    assign busy       = r_busy;
    assign done       = r_done;

endmodule
